aes_desifre: RTL
================

AES_DESIFRE -- requirements
Module: aes_desifre

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: anahtar  input  128  AES-128 cipher key, FIPS-197 byte order (MSB = byte 0).
REQ-004 SHALL have port: anahtar_yukle  input  1  one-cycle request to re-expand anahtar.
REQ-005 SHALL have port: sifre  input  128  ciphertext block.
REQ-006 SHALL have port: g_gecerli  input  1  sifre valid.
REQ-007 SHALL have port: hazir  output  1  block accepted when g_gecerli && hazir at a rising edge.
REQ-008 SHALL have port: blok  output  128  recovered plaintext.
REQ-009 SHALL have port: c_gecerli  output  1  blok valid, one-cycle pulse, no backpressure.

Function
REQ-010 SHALL implement an FSM with states KEY_EXP, IDLE, ROUND, FINAL.
REQ-011 SHALL, in KEY_EXP, compute one round key per cycle, starting from the sampled anahtar: rk[0] = key, rk[1]..rk[10] over 10 cycles, stored in 11x128 registers; then go to IDLE.
REQ-012 SHALL sample anahtar on the first rising edge after rst deasserts and enter KEY_EXP automatically.
REQ-013 SHALL assert hazir only in IDLE, combinationally from the state register.
REQ-014 SHALL, on accept in IDLE, load state <= sifre ^ rk[10], set round counter to 9, and go to ROUND.
REQ-015 SHALL, in ROUND, apply InvShiftRows, InvSubBytes, AddRoundKey(rk[ctr]), InvMixColumns each cycle, decrement ctr, and go to FINAL after ctr = 1.
REQ-016 SHALL, in FINAL, apply InvShiftRows, InvSubBytes, AddRoundKey(rk[0]) with no InvMixColumns, register blok, pulse c_gecerli, and go to IDLE.
REQ-017 Latency SHALL be exact: c_gecerli is high in the 11th cycle after the accept edge (accept at edge 0, blok valid after edge 10); maximum throughput is one block per 11 cycles.
REQ-018 blok SHALL hold its value until the next FINAL and change only there; c_gecerli SHALL be 0 in all other cycles.
REQ-019 anahtar_yukle SHALL be acted on only in IDLE (go to KEY_EXP, sample anahtar) and ignored in KEY_EXP, ROUND and FINAL.
REQ-020 If g_gecerli and anahtar_yukle are both high in IDLE, the block SHALL be accepted with the current keys and anahtar_yukle ignored.
REQ-021 g_gecerli SHALL be ignored while hazir = 0; sifre SHALL be sampled only at the accept edge.
REQ-022 Round keys SHALL not be modified outside KEY_EXP.

Reset
REQ-023 On rst = 0, the block SHALL asynchronously reset to: FSM = KEY_EXP-pending (idle-wait for release), hazir = 0, c_gecerli = 0, blok = 0, state = 0, ctr = 0, all round keys = 0.
REQ-024 A reset asserted mid-ROUND or mid-KEY_EXP SHALL abort the operation with no c_gecerli pulse, and SHALL be followed by a fresh key expansion.

Structure
REQ-025 Forward S-box, inverse S-box, Rcon table and FSM state encodings SHALL live in a shared package (aes_pkg).
REQ-026 One sub-module, inv_round (combinational: state, round key, last flag -> next state), SHALL be instantiated once.
REQ-027 Key expansion SHALL reuse the forward S-box from the package; the inverse key schedule SHALL not be precomputed.

Verification
REQ-028 Key 000102030405060708090a0b0c0d0e0f, sifre 69c4e0d86a7b0430d8cdb78070b4c55a -> blok 00112233445566778899aabbccddeeff with c_gecerli 11 cycles after accept.
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c, sifre 3925841d02dc09fbdc118597196a0b32 -> blok 3243f6a8885a308d313198a2e0370734.
REQ-030 Back-to-back: g_gecerli held high with two ciphertexts -> the second is accepted exactly 11 cycles after the first; both plaintexts are correct, and hazir = 0 in between.
REQ-031 Key reload: pulse anahtar_yukle in IDLE -> hazir = 0 for 10 cycles; the next decrypt uses the new key; an anahtar_yukle pulse during ROUND changes nothing.
REQ-032 Reset at round 5: rst low for 1 cycle -> outputs 0 immediately, no c_gecerli, re-expansion completes, and a subsequent vector decrypts correctly.
REQ-033 Simultaneous g_gecerli and anahtar_yukle in IDLE -> the block decrypts with the old key, and KEY_EXP is not entered.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES tables and helpers for the decryptor.
//   fsm_e      : controller states (KEY_WAIT is the post-reset pending state)
//   sbox       : forward S-box (used by the key schedule)
//   inv_sbox   : inverse S-box (used by the round datapath)
//   rcon       : round constant for key-schedule step i (1..10)
//   xtime      : GF(2^8) multiply by 2
//   key_step   : derive round key i from round key i-1
package aes_pkg;

  typedef enum logic [2:0] {
    ST_KEY_WAIT,
    ST_KEY_EXP,
    ST_IDLE,
    ST_ROUND,
    ST_FINAL
  } fsm_e;

  localparam int NR = 10;

  // Byte b lives at bits [8*(255-b)+7 -: 8], i.e. entry 0 is the MSB byte.
  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // 8*(255-b)+7 == {~b, 3'b111}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_T[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_T[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = prev[31:0];
    // SubWord(RotWord(w3)) ^ Rcon
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = w3           ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/inv_round.sv
// One AES inverse round, purely combinational:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last).
// Ports: state_in (128), round_key (128), last (1) -> state_out (128).
// Byte i of a 128-bit block sits at [127-8i -: 8]; state[r][c] is byte 4c+r.
module inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction
  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction
  function automatic logic [7:0] muld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction
  function automatic logic [7:0] mule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

  logic [127:0] ark, mixed;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // row r rotates right by r: out[r][c] = in[r][(c-r) mod 4]
      assign ark[127-8*(4*c+r) -: 8] =
        inv_sbox(state_in[127-8*(4*((c-r+4)%4)+r) -: 8]) ^ round_key[127-8*(4*c+r) -: 8];
    end
    assign mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  assign state_out = last ? ark : mixed;

endmodule

// File: rtl/aes_desifre.sv
// Iterative AES-128 decryptor, one inverse round per cycle.
//   clk, rst (async active-low)
//   anahtar / anahtar_yukle : key and one-cycle reload request (honoured in IDLE only)
//   sifre / g_gecerli / hazir : ciphertext handshake, accepted on g_gecerli && hazir
//   blok / c_gecerli          : plaintext and one-cycle valid pulse, 11 cycles after accept
// Round keys are expanded forward once (10 cycles) into 11 registers and read
// back in reverse order during decryption.
module aes_desifre
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] anahtar,
  input  logic         anahtar_yukle,
  input  logic [127:0] sifre,
  input  logic         g_gecerli,
  output logic         hazir,
  output logic [127:0] blok,
  output logic         c_gecerli
);

  fsm_e         st_q, st_d;
  logic [127:0] state_q;
  logic [3:0]   ctr_q;
  logic [127:0] rk [NR+1];
  logic [127:0] rk_cur, rk_prev, round_out;

  // In KEY_EXP ctr is the index being produced; in ROUND it is the key in use,
  // and it reaches 0 exactly when FINAL needs rk[0].
  assign rk_cur  = rk[ctr_q];
  assign rk_prev = rk[ctr_q - 4'd1];

  inv_round u_inv_round (
    .state_in  (state_q),
    .round_key (rk_cur),
    .last      (st_q == ST_FINAL),
    .state_out (round_out)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= ST_KEY_WAIT;
    else      st_q <= st_d;
  end

  // next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_KEY_WAIT: st_d = ST_KEY_EXP;
      ST_KEY_EXP:  if (ctr_q == 4'(NR)) st_d = ST_IDLE;
      // a block request wins over a simultaneous key reload
      ST_IDLE:     if (g_gecerli) st_d = ST_ROUND;
                   else if (anahtar_yukle) st_d = ST_KEY_EXP;
      ST_ROUND:    if (ctr_q == 4'd1) st_d = ST_FINAL;
      ST_FINAL:    st_d = ST_IDLE;
      default:     st_d = ST_KEY_WAIT;
    endcase
  end

  // outputs
  always_comb begin
    hazir = (st_q == ST_IDLE);
  end

  // datapath and round-key storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= '0;
      ctr_q     <= '0;
      blok      <= '0;
      c_gecerli <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      c_gecerli <= (st_q == ST_FINAL);
      case (st_q)
        // rk[0] is the raw key, latched on the edge that enters KEY_EXP
        ST_KEY_WAIT: begin
          rk[0] <= anahtar;
          ctr_q <= 4'd1;
        end
        ST_KEY_EXP: begin
          rk[ctr_q] <= key_step(rk_prev, rcon(ctr_q));
          ctr_q     <= (ctr_q == 4'(NR)) ? 4'd0 : ctr_q + 4'd1;
        end
        ST_IDLE: begin
          if (g_gecerli) begin
            state_q <= sifre ^ rk[NR];
            ctr_q   <= 4'(NR - 1);
          end else if (anahtar_yukle) begin
            rk[0] <= anahtar;
            ctr_q <= 4'd1;
          end
        end
        ST_ROUND: begin
          state_q <= round_out;
          ctr_q   <= ctr_q - 4'd1;
        end
        ST_FINAL: begin
          blok  <= round_out;
          ctr_q <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
